// File: rtl/count_pkg.sv
// Shared definitions for the mod-12/mod-11 counter and its wrap monitor.
//   state_t        : monitor state encoding
//   TOP_T1_DEF     : terminal count when t=1 (counter runs 0..11)
//   TOP_T0_DEF     : terminal count when t=0 (counter runs 1..10, parks at 0)
//   SEG_TABLE      : 16-entry 7-segment patterns {g,f,e,d,c,b,a}, active-high
package count_pkg;

    typedef enum logic [1:0] {
        StInit  = 2'd0,
        StTrack = 2'd1,
        StFault = 2'd2
    } state_t;

    localparam int unsigned TOP_T1_DEF = 11;
    localparam int unsigned TOP_T0_DEF = 10;

    // Element 15 is listed first. 0..9 digits, 10 'A', 11 'b', 12..15 blank.
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'h00, 7'h00, 7'h00, 7'h00,
        7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66,
        7'h4F, 7'h5B, 7'h06, 7'h3F
    };

endpackage

// File: rtl/seg7_dec.sv
// Combinational 4-bit to 7-segment decode.
//   digit : value to display
//   seg   : segments {g,f,e,d,c,b,a}, active-high, blank for 12..15
module seg7_dec
    import count_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_TABLE[digit];
    end

endmodule

// File: rtl/count_wrap_monitor.sv
// Sequence monitor for the mod-12/mod-11 counter.
// Classifies each step of q against the previous sample, pulses on legal
// roll-overs and early returns to 0, latches illegal steps, keeps a
// saturating roll-over total and drives a registered 7-segment view of q.
//   clk      : rising-edge clock
//   res_n    : asynchronous active-low reset
//   q        : counter value
//   t        : counter mode (selects terminal count)
//   clr      : synchronous clear of statistics and fault
//   wrap     : one-cycle pulse, legal roll-over
//   abort    : one-cycle pulse, early return to 0
//   wraps    : saturating roll-over total
//   err      : sticky illegal-step flag
//   seg      : registered 7-segment pattern of q
//   tracking : high while sequence checking is active
module count_wrap_monitor
    import count_pkg::*;
#(
    parameter int unsigned TOP_T1 = TOP_T1_DEF,
    parameter int unsigned TOP_T0 = TOP_T0_DEF,
    parameter int unsigned WRAP_W = 8
) (
    input  logic              clk,
    input  logic              res_n,
    input  logic [3:0]        q,
    input  logic              t,
    input  logic              clr,
    output logic              wrap,
    output logic              abort,
    output logic [WRAP_W-1:0] wraps,
    output logic              err,
    output logic [6:0]        seg,
    output logic              tracking
);

    state_t            state_q, state_d;
    logic [3:0]        q_prev_q;        // previous sample of q
    logic              wrap_q, wrap_d;
    logic              abort_q, abort_d;
    logic [WRAP_W-1:0] wraps_q, wraps_d;
    logic              err_q, err_d;
    logic [6:0]        seg_q;
    logic [6:0]        seg_dec;
    logic [3:0]        top;
    logic              step_ok;

    seg7_dec u_seg7_dec (
        .digit (q),
        .seg   (seg_dec)
    );

    assign top = t ? 4'(TOP_T1) : 4'(TOP_T0);

    // 15 -> 0 must not count as an increment; it falls through to the q==0 rules.
    assign step_ok = (q_prev_q != 4'hF) && (q == q_prev_q + 4'd1);

    always_comb begin
        state_d = state_q;
        wrap_d  = 1'b0;
        abort_d = 1'b0;
        wraps_d = wraps_q;
        err_d   = err_q;
        if (clr) begin
            state_d = StInit;
            wraps_d = '0;
            err_d   = 1'b0;
        end else begin
            unique case (state_q)
                StInit: begin
                    state_d = StTrack;
                end
                StTrack: begin
                    if (step_ok) begin
                        state_d = StTrack;
                    end else if (q == 4'd0 && q_prev_q == top) begin
                        wrap_d = 1'b1;
                        if (!(&wraps_q)) begin
                            wraps_d = wraps_q + WRAP_W'(1);
                        end
                    end else if (q == 4'd0 && q_prev_q == 4'd0) begin
                        state_d = StTrack;
                    end else if (q == 4'd0) begin
                        abort_d = 1'b1;
                    end else begin
                        err_d   = 1'b1;
                        state_d = StFault;
                    end
                end
                StFault: begin
                    err_d = 1'b1;
                end
                default: begin
                    state_d = StInit;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            state_q  <= StInit;
            q_prev_q <= 4'd0;
            wrap_q   <= 1'b0;
            abort_q  <= 1'b0;
            wraps_q  <= '0;
            err_q    <= 1'b0;
            seg_q    <= 7'd0;
        end else begin
            state_q  <= state_d;
            q_prev_q <= q;
            wrap_q   <= wrap_d;
            abort_q  <= abort_d;
            wraps_q  <= wraps_d;
            err_q    <= err_d;
            seg_q    <= seg_dec;
        end
    end

    assign wrap     = wrap_q;
    assign abort    = abort_q;
    assign wraps    = wraps_q;
    assign err      = err_q;
    assign seg      = seg_q;
    assign tracking = (state_q == StTrack);

endmodule

// File: tb/tb_count_wrap_monitor.sv
module tb_count_wrap_monitor;

    logic       clk = 1'b0;
    logic       res_n;
    logic [3:0] q;
    logic       t;
    logic       clr;

    logic       wrap, abort, err, tracking;
    logic [7:0] wraps;
    logic [6:0] seg;
    logic       wrap2, abort2, err2, tracking2;
    logic [1:0] wraps2;
    logic [6:0] seg2;

    int total = 0;
    int bad   = 0;

    // Reference model state.
    bit         m_hist;
    bit         m_fault;
    logic [3:0] m_prev;
    int         m_w8;
    int         m_w2;
    logic       e_wrap, e_abort;
    logic [6:0] e_seg;

    count_wrap_monitor #(.WRAP_W(8)) u_dut (
        .clk      (clk),
        .res_n    (res_n),
        .q        (q),
        .t        (t),
        .clr      (clr),
        .wrap     (wrap),
        .abort    (abort),
        .wraps    (wraps),
        .err      (err),
        .seg      (seg),
        .tracking (tracking)
    );

    count_wrap_monitor #(.WRAP_W(2)) u_dut2 (
        .clk      (clk),
        .res_n    (res_n),
        .q        (q),
        .t        (t),
        .clr      (clr),
        .wrap     (wrap2),
        .abort    (abort2),
        .wraps    (wraps2),
        .err      (err2),
        .seg      (seg2),
        .tracking (tracking2)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] seg_ref(input logic [3:0] v);
        case (v)
            4'd0:    return 7'b0111111;
            4'd1:    return 7'b0000110;
            4'd2:    return 7'b1011011;
            4'd3:    return 7'b1001111;
            4'd4:    return 7'b1100110;
            4'd5:    return 7'b1101101;
            4'd6:    return 7'b1111101;
            4'd7:    return 7'b0000111;
            4'd8:    return 7'b1111111;
            4'd9:    return 7'b1101111;
            4'd10:   return 7'b1110111;
            4'd11:   return 7'b1111100;
            default: return 7'b0000000;
        endcase
    endfunction

    task automatic model_reset();
        m_hist  = 0;
        m_fault = 0;
        m_prev  = 4'd0;
        m_w8    = 0;
        m_w2    = 0;
        e_wrap  = 1'b0;
        e_abort = 1'b0;
        e_seg   = 7'd0;
    endtask

    // Applies one sample to the model using the step-classification rules.
    task automatic model_step(input logic [3:0] qv, input logic tv, input logic cv);
        int top;
        top     = tv ? 11 : 10;
        e_wrap  = 1'b0;
        e_abort = 1'b0;
        e_seg   = seg_ref(qv);
        if (cv) begin
            m_hist  = 0;
            m_fault = 0;
            m_w8    = 0;
            m_w2    = 0;
        end else if (!m_hist) begin
            m_hist = 1;
        end else if (!m_fault) begin
            if (int'(qv) == int'(m_prev) + 1) begin
                // legal increment
            end else if (qv == 0 && int'(m_prev) == top) begin
                e_wrap = 1'b1;
                if (m_w8 < 255) m_w8++;
                if (m_w2 < 3) m_w2++;
            end else if (qv == 0 && m_prev == 0) begin
                // parked
            end else if (qv == 0) begin
                e_abort = 1'b1;
            end else begin
                m_fault = 1;
            end
        end
        m_prev = qv;
    endtask

    // Drive one sample, let the DUT take it, then advance the model.
    task automatic cyc(input logic [3:0] qv, input logic tv, input logic cv);
        q   = qv;
        t   = tv;
        clr = cv;
        @(posedge clk);
        #1;
        model_step(qv, tv, cv);
    endtask

    task automatic test_reset();
        res_n = 1'b0;
        q = 4'd0; t = 1'b1; clr = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        total++;
        if ({wrap, abort, wraps, err, seg, tracking} !== 19'd0) begin
            bad++;
            $display("FAIL reset_outputs: got %0h exp 0", {wrap, abort, wraps, err, seg, tracking});
        end
        @(negedge clk);
        res_n = 1'b1;
    endtask

    task automatic test_t1_wrap();
        cyc(4'd0, 1'b1, 1'b0);
        for (int i = 1; i <= 11; i++) begin
            cyc(4'(i), 1'b1, 1'b0);
            total++;
            if (wrap !== 1'b0 || abort !== 1'b0) begin
                bad++;
                $display("FAIL t1_no_pulse: q=%0d got wrap=%b abort=%b exp 0 0", i, wrap, abort);
            end
        end
        cyc(4'd0, 1'b1, 1'b0);
        total++;
        if (wrap !== 1'b1) begin
            bad++;
            $display("FAIL t1_wrap_pulse: got %b exp 1", wrap);
        end
        total++;
        if (wraps !== 8'd1) begin
            bad++;
            $display("FAIL t1_wraps1: got %0d exp 1", wraps);
        end
        for (int i = 1; i <= 11; i++) cyc(4'(i), 1'b1, 1'b0);
        cyc(4'd0, 1'b1, 1'b0);
        total++;
        if (wraps !== 8'd2 || err !== 1'b0) begin
            bad++;
            $display("FAIL t1_wraps2: got wraps=%0d err=%b exp 2 0", wraps, err);
        end
    endtask

    task automatic test_t0_park();
        cyc(4'd0, 1'b0, 1'b1);
        cyc(4'd0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            cyc(4'd0, 1'b0, 1'b0);
            total++;
            if (wrap !== 1'b0 || abort !== 1'b0 || tracking !== 1'b1 || err !== 1'b0) begin
                bad++;
                $display("FAIL t0_park: got wrap=%b abort=%b trk=%b err=%b exp 0 0 1 0",
                         wrap, abort, tracking, err);
            end
        end
        for (int i = 1; i <= 10; i++) cyc(4'(i), 1'b0, 1'b0);
        cyc(4'd0, 1'b0, 1'b0);
        total++;
        if (wrap !== 1'b1 || wraps !== 8'd1) begin
            bad++;
            $display("FAIL t0_wrap: got wrap=%b wraps=%0d exp 1 1", wrap, wraps);
        end
    endtask

    task automatic test_mode_switch();
        for (int i = 1; i <= 7; i++) cyc(4'(i), 1'b1, 1'b0);
        cyc(4'd8, 1'b0, 1'b0);
        cyc(4'd9, 1'b0, 1'b0);
        cyc(4'd10, 1'b0, 1'b0);
        total++;
        if (wrap !== 1'b0) begin
            bad++;
            $display("FAIL switch_early_wrap: got %b exp 0", wrap);
        end
        cyc(4'd0, 1'b0, 1'b0);
        total++;
        if (wrap !== 1'b1 || wraps !== 8'd2) begin
            bad++;
            $display("FAIL switch_wrap: got wrap=%b wraps=%0d exp 1 2", wrap, wraps);
        end
        for (int i = 1; i <= 5; i++) cyc(4'(i), 1'b0, 1'b0);
        cyc(4'd0, 1'b0, 1'b0);
        total++;
        if (abort !== 1'b1 || wrap !== 1'b0 || wraps !== 8'd2 || err !== 1'b0) begin
            bad++;
            $display("FAIL abort: got abort=%b wrap=%b wraps=%0d err=%b exp 1 0 2 0",
                     abort, wrap, wraps, err);
        end
        cyc(4'd0, 1'b0, 1'b0);
        total++;
        if (abort !== 1'b0) begin
            bad++;
            $display("FAIL abort_one_cycle: got %b exp 0", abort);
        end
    endtask

    task automatic test_fault();
        cyc(4'd1, 1'b1, 1'b0);
        cyc(4'd2, 1'b1, 1'b0);
        cyc(4'd3, 1'b1, 1'b0);
        cyc(4'd6, 1'b1, 1'b0);
        total++;
        if (err !== 1'b1 || tracking !== 1'b0) begin
            bad++;
            $display("FAIL fault_entry: got err=%b trk=%b exp 1 0", err, tracking);
        end
        for (int i = 7; i <= 11; i++) cyc(4'(i), 1'b1, 1'b0);
        cyc(4'd0, 1'b1, 1'b0);
        total++;
        if (wrap !== 1'b0 || wraps !== 8'(m_w8) || err !== 1'b1) begin
            bad++;
            $display("FAIL fault_frozen: got wrap=%b wraps=%0d err=%b exp 0 %0d 1",
                     wrap, wraps, err, m_w8);
        end
        cyc(4'd0, 1'b1, 1'b1);
        total++;
        if (err !== 1'b0 || wraps !== 8'd0 || tracking !== 1'b0) begin
            bad++;
            $display("FAIL fault_clr: got err=%b wraps=%0d trk=%b exp 0 0 0", err, wraps, tracking);
        end
        cyc(4'd0, 1'b1, 1'b0);
        total++;
        if (tracking !== 1'b1) begin
            bad++;
            $display("FAIL clr_to_track: got %b exp 1", tracking);
        end
    endtask

    task automatic test_saturate();
        cyc(4'd0, 1'b1, 1'b1);
        cyc(4'd0, 1'b1, 1'b0);
        for (int p = 0; p < 5; p++) begin
            for (int i = 1; i <= 11; i++) cyc(4'(i), 1'b1, 1'b0);
            cyc(4'd0, 1'b1, 1'b0);
        end
        total++;
        if (wraps2 !== 2'd3 || wraps !== 8'd5) begin
            bad++;
            $display("FAIL saturate: got wraps2=%0d wraps=%0d exp 3 5", wraps2, wraps);
        end
        for (int i = 1; i <= 11; i++) cyc(4'(i), 1'b1, 1'b0);
        cyc(4'd0, 1'b1, 1'b1);
        total++;
        if (wraps !== 8'd0 || wraps2 !== 2'd0 || wrap !== 1'b0 || wrap2 !== 1'b0) begin
            bad++;
            $display("FAIL clr_beats_wrap: got wraps=%0d wraps2=%0d wrap=%b wrap2=%b exp 0 0 0 0",
                     wraps, wraps2, wrap, wrap2);
        end
    endtask

    task automatic test_async_reset();
        cyc(4'd0, 1'b1, 1'b0);
        for (int i = 1; i <= 11; i++) cyc(4'(i), 1'b1, 1'b0);
        cyc(4'd0, 1'b1, 1'b0);
        for (int i = 1; i <= 6; i++) cyc(4'(i), 1'b1, 1'b0);
        #2;
        res_n = 1'b0;
        #1;
        model_reset();
        total++;
        if ({wrap, abort, wraps, err, seg, tracking, wraps2} !== 21'd0) begin
            bad++;
            $display("FAIL async_reset: got %0h exp 0",
                     {wrap, abort, wraps, err, seg, tracking, wraps2});
        end
        @(negedge clk);
        res_n = 1'b1;
        cyc(4'd0, 1'b1, 1'b0);
        cyc(4'd1, 1'b1, 1'b0);
        total++;
        if (err !== 1'b0 || tracking !== 1'b1 || wrap !== 1'b0 || abort !== 1'b0) begin
            bad++;
            $display("FAIL post_reset_step: got err=%b trk=%b wrap=%b abort=%b exp 0 1 0 0",
                     err, tracking, wrap, abort);
        end
    endtask

    task automatic test_seg_sweep();
        for (int v = 0; v < 16; v++) begin
            cyc(4'(v), 1'b1, 1'b0);
            total++;
            if (seg !== seg_ref(4'(v))) begin
                bad++;
                $display("FAIL seg_sweep: q=%0d got %b exp %b", v, seg, seg_ref(4'(v)));
            end
        end
    endtask

    task automatic test_random();
        logic [3:0] cur;
        logic       tv;
        logic       cv;
        int         r;
        int         top;
        logic [20:0] got, exp;
        cur = q;
        tv  = 1'b1;
        cyc(cur, tv, 1'b1);
        for (int n = 0; n < 600; n++) begin
            r  = int'($urandom_range(0, 99));
            cv = (r < 3);
            if (r >= 3 && r < 7) tv = ~tv;
            top = tv ? 11 : 10;
            if (r < 88) begin
                if (int'(cur) >= top) cur = 4'd0;
                else if (!tv && cur == 0 && r < 20) cur = 4'd0;
                else cur = cur + 4'd1;
            end else begin
                cur = 4'($urandom_range(0, 15));
            end
            cyc(cur, tv, cv);
            got = {wrap, abort, err, tracking, wraps, seg, wraps2};
            exp = {e_wrap, e_abort, 1'(m_fault), 1'(m_hist && !m_fault), 8'(m_w8), e_seg,
                   2'(m_w2)};
            total++;
            if (got !== exp) begin
                bad++;
                $display("FAIL random[%0d]: q=%0d t=%b clr=%b got %b exp %b", n, cur, tv, cv,
                         got, exp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_t1_wrap();
        test_t0_park();
        test_mode_switch();
        test_fault();
        test_saturate();
        test_async_reset();
        test_seg_sweep();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
